// File: rtl/trivium_seq_ctrl.sv
// -----------------------------------------------------------------------------
// trivium_seq_ctrl
// Sequencer for a Trivium cipher core. It shifts the IV then the key (LSB
// first) into the input shift register and strobes the engine to load its
// state. It then clocks the engine through the warm-up and finally grants one
// keystream bit per downstream request.
//
// Ports
//   clk_i        system clock (rising edge)
//   n_rst_i      asynchronous active-low reset
//   start_i      begin a load (honoured only in IDLE)
//   stop_i       abort / end session, returns to IDLE from any state
//   din_i        serial IV/key bit from the host loader
//   din_valid_i  din_i carries a bit
//   din_ready_o  controller accepts a bit this cycle (LOAD)
//   sr_ce_o      shift enable for the input shift register
//   sr_din_o     serial bit to the input shift register (= din_i)
//   eng_load_o   one-cycle strobe: engine copies shift-register contents
//   eng_ce_o     engine clock enable
//   ks_req_i     downstream requests one keystream bit this cycle
//   ks_valid_o   engine output bit this cycle is valid keystream
//   busy_o       any state other than IDLE
//   ready_o      warm-up complete (RUN)
// -----------------------------------------------------------------------------
module trivium_seq_ctrl #(
  parameter int IV_SZ    = 80,
  parameter int KEY_SZ   = 80,
  parameter int INIT_CYC = 1152,
  parameter int CNT_W    = 11
) (
  input  logic clk_i,
  input  logic n_rst_i,
  input  logic start_i,
  input  logic stop_i,
  input  logic din_i,
  input  logic din_valid_i,
  output logic din_ready_o,
  output logic sr_ce_o,
  output logic sr_din_o,
  output logic eng_load_o,
  output logic eng_ce_o,
  input  logic ks_req_i,
  output logic ks_valid_o,
  output logic busy_o,
  output logic ready_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_LATCH = 3'd2,
    S_INIT  = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  // Terminal counts: the beat / cycle carrying these values is the last one.
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(IV_SZ + KEY_SZ - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic; stop_i overrides every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // Gaps (no valid beat) hold the counter and do not shift.
        if (din_valid_i) begin
          if (cnt_q == LOAD_LAST) begin
            state_d = S_LATCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_LATCH: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
      S_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort has priority, including over the terminal beats above; this also
    // makes start_i together with stop_i in IDLE a no-op.
    if (stop_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      state_d = state_d;
    end
  end

  // Output decode: state-only strobes plus same-cycle gated handshakes.
  always_comb begin
    din_ready_o = (state_q == S_LOAD);
    sr_ce_o     = (state_q == S_LOAD) & din_valid_i;
    sr_din_o    = din_i;
    eng_load_o  = (state_q == S_LATCH);
    eng_ce_o    = (state_q == S_INIT) | ((state_q == S_RUN) & ks_req_i);
    ks_valid_o  = (state_q == S_RUN) & ks_req_i;
    busy_o      = (state_q != S_IDLE);
    ready_o     = (state_q == S_RUN);
  end

endmodule

// File: tb/tb_trivium_seq_ctrl.sv
// Self-checking bench for trivium_seq_ctrl.
module tb_trivium_seq_ctrl;

  logic clk_i = 1'b0;
  logic n_rst_i, start_i, stop_i, din_i, din_valid_i, ks_req_i;
  logic din_ready_o, sr_ce_o, sr_din_o, eng_load_o, eng_ce_o;
  logic ks_valid_o, busy_o, ready_o;

  int checks   = 0;
  int failures = 0;

  // Expected {sr_ce, eng_ce, ks_valid, ready, busy} pushed when driven.
  logic [4:0] sb_q[$];

  typedef struct {
    logic ks_req;
    logic start;
    logic din_valid;
    logic exp_ce;
    logic exp_ksv;
  } run_vec_t;

  trivium_seq_ctrl #(
    .IV_SZ(80), .KEY_SZ(80), .INIT_CYC(1152), .CNT_W(11)
  ) dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .start_i(start_i), .stop_i(stop_i),
    .din_i(din_i), .din_valid_i(din_valid_i), .din_ready_o(din_ready_o),
    .sr_ce_o(sr_ce_o), .sr_din_o(sr_din_o), .eng_load_o(eng_load_o),
    .eng_ce_o(eng_ce_o), .ks_req_i(ks_req_i), .ks_valid_o(ks_valid_o),
    .busy_o(busy_o), .ready_o(ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_load();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic feed(input int n);
    din_valid_i = 1'b1;
    repeat (n) begin
      din_i = 1'($urandom);
      cyc();
    end
    din_valid_i = 1'b0;
  endtask

  // Assert reset mid-cycle, check all outputs drop immediately, release.
  task automatic reset_check(input string name);
    din_valid_i = 1'b1;
    ks_req_i    = 1'b1;
    din_i       = 1'b1;
    #1;
    chk({name, "_busy_before"}, 32'(busy_o), 32'd1);
    n_rst_i = 1'b0;
    #1;
    chk({name, "_outs"}, 32'({din_ready_o, sr_ce_o, eng_load_o, eng_ce_o,
                              ks_valid_o, busy_o, ready_o}), 32'd0);
    chk({name, "_sr_din"}, 32'(sr_din_o), 32'd1);
    din_valid_i = 1'b0;
    ks_req_i    = 1'b0;
    din_i       = 1'b0;
    #1;
    n_rst_i = 1'b1;
    cyc();
    chk({name, "_idle_after"}, 32'(busy_o), 32'd0);
  endtask

  // Full load + warm-up from IDLE; ends in RUN (if the DUT gets there).
  task automatic full_session(input bit throttle);
    int  cycn, shifts, loads, load_shift, load_cyc, ces, bad, ready_cyc;
    bit  done;
    cycn = 1; shifts = 0; loads = 0; load_shift = -1; load_cyc = -1;
    ces = 0; bad = 0; ready_cyc = -1; done = 1'b0;
    start_load();
    chk("ready_after_start", 32'(din_ready_o), 32'd1);
    while (!done && cycn < 4000) begin
      din_valid_i = throttle ? ($urandom_range(0, 99) < 30) : 1'b1;
      din_i       = 1'($urandom);
      start_i     = (cycn == 700);
      #1;
      if (sr_ce_o) begin
        shifts++;
        if (sr_din_o !== din_i) bad++;
      end
      if (sr_ce_o !== (din_ready_o & din_valid_i)) bad++;
      if (eng_load_o) begin
        loads++;
        load_shift = shifts;
        load_cyc   = cycn;
      end
      if (eng_ce_o) ces++;
      if (ready_o) begin
        ready_cyc = cycn;
        done      = 1'b1;
      end else begin
        cyc();
        cycn++;
      end
    end
    start_i     = 1'b0;
    din_valid_i = 1'b0;
    chk("shift_count", 32'(shifts), 32'd160);
    chk("shift_bits_bad", 32'(bad), 32'd0);
    chk("load_strobes", 32'(loads), 32'd1);
    chk("load_after_beat", 32'(load_shift), 32'd160);
    chk("init_ce_count", 32'(ces), 32'd1152);
    chk("ready_reached", 32'(done), 32'd1);
    if (!throttle) begin
      chk("load_cycle", 32'(load_cyc), 32'd161);
      chk("ready_cycle", 32'(ready_cyc), 32'd1314);
    end
  endtask

  run_vec_t vecs[6];

  initial begin
    n_rst_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; din_i = 1'b0;
    din_valid_i = 1'b0; ks_req_i = 1'b0;

    vecs[0] = '{ks_req: 1'b1, start: 1'b0, din_valid: 1'b1, exp_ce: 1'b1, exp_ksv: 1'b1};
    vecs[1] = '{ks_req: 1'b0, start: 1'b0, din_valid: 1'b0, exp_ce: 1'b0, exp_ksv: 1'b0};
    vecs[2] = '{ks_req: 1'b1, start: 1'b1, din_valid: 1'b1, exp_ce: 1'b1, exp_ksv: 1'b1};
    vecs[3] = '{ks_req: 1'b1, start: 1'b0, din_valid: 1'b0, exp_ce: 1'b1, exp_ksv: 1'b1};
    vecs[4] = '{ks_req: 1'b0, start: 1'b1, din_valid: 1'b1, exp_ce: 1'b0, exp_ksv: 1'b0};
    vecs[5] = '{ks_req: 1'b0, start: 1'b0, din_valid: 1'b0, exp_ce: 1'b0, exp_ksv: 1'b0};

    // Power-on reset.
    #3;
    chk("por_outs", 32'({din_ready_o, sr_ce_o, eng_load_o, eng_ce_o,
                         ks_valid_o, busy_o, ready_o}), 32'd0);
    #10;
    n_rst_i = 1'b1;
    cyc();
    chk("idle_busy", 32'(busy_o), 32'd0);

    // Reset while IDLE.
    din_valid_i = 1'b1; ks_req_i = 1'b1; #1;
    chk("idle_no_strobes", 32'({din_ready_o, sr_ce_o, eng_ce_o, ks_valid_o}), 32'd0);
    din_valid_i = 1'b0; ks_req_i = 1'b0;
    n_rst_i = 1'b0; #1; n_rst_i = 1'b1;
    cyc();

    // Continuous load to RUN, then keystream request pattern via scoreboard.
    full_session(1'b0);
    for (int i = 0; i < 6; i++) begin
      ks_req_i    = vecs[i].ks_req;
      start_i     = vecs[i].start;
      din_valid_i = vecs[i].din_valid;
      sb_q.push_back({1'b0, vecs[i].exp_ce, vecs[i].exp_ksv, 1'b1, 1'b1});
      #1;
      if (sb_q.size() > 0) begin
        logic [4:0] e;
        e = sb_q.pop_front();
        chk($sformatf("run_vec%0d", i),
            32'({sr_ce_o, eng_ce_o, ks_valid_o, ready_o, busy_o}), 32'(e));
      end
      cyc();
    end
    start_i = 1'b0; ks_req_i = 1'b0; din_valid_i = 1'b0;
    reset_check("rst_run");

    // Reset at LOAD beat 40, then a throttled load must still need 160 beats.
    start_load();
    feed(40);
    reset_check("rst_load40");
    full_session(1'b1);
    reset_check("rst_run2");

    // Reset at INIT cycle 600.
    start_load();
    feed(160);
    chk("latch_strobe", 32'(eng_load_o), 32'd1);
    cyc();
    repeat (599) cyc();
    #1;
    chk("init600_ce", 32'({eng_ce_o, ready_o}), 32'b10);
    reset_check("rst_init600");

    // stop_i on the last LOAD beat: no load strobe, back to IDLE.
    start_load();
    feed(159);
    din_valid_i = 1'b1; stop_i = 1'b1;
    cyc();
    din_valid_i = 1'b0; stop_i = 1'b0;
    begin
      int seen = 0;
      repeat (4) begin
        #1;
        if (eng_load_o || ready_o || busy_o) seen++;
        cyc();
      end
      chk("stop_last_beat", 32'(seen), 32'd0);
    end

    // stop_i on the terminal INIT cycle (cnt = 1151): RUN never reached.
    start_load();
    feed(160);
    cyc();
    repeat (1151) cyc();
    #1;
    chk("init_term_busy", 32'({busy_o, ready_o}), 32'b10);
    stop_i = 1'b1;
    cyc();
    stop_i = 1'b0;
    begin
      int seen = 0;
      repeat (4) begin
        #1;
        if (ready_o || busy_o || eng_ce_o) seen++;
        cyc();
      end
      chk("stop_init_term", 32'(seen), 32'd0);
    end

    // start_i together with stop_i in IDLE stays IDLE.
    start_i = 1'b1; stop_i = 1'b1;
    cyc();
    start_i = 1'b0; stop_i = 1'b0;
    #1;
    chk("start_stop_idle", 32'({busy_o, din_ready_o}), 32'd0);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
